// File: rtl/iob_axistream_in.sv
// AXI-Stream receiver that packs TDATA_W beats into 32-bit words, queues them in a FIFO
// and exposes them to a CPU over a simple iob register port. Optional macro: IOB_AXISTREAM_IN_LEVEL_EN.
module iob_axistream_in #(
  parameter int TDATA_W         = 8,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iob_avalid,
  input  logic [ADDR_W-1:0]     iob_addr,
  input  logic [DATA_W-1:0]     iob_wdata,
  input  logic [DATA_W/8-1:0]   iob_wstrb,
  output logic [DATA_W-1:0]     iob_rdata,
  output logic                  iob_rvalid,
  output logic                  iob_ready,
  input  logic [TDATA_W-1:0]    tdata,
  input  logic                  tvalid,
  output logic                  tready,
  input  logic                  tlast
);

  localparam int N     = 32 / TDATA_W;
  localparam int K_W   = (N > 1) ? $clog2(N) : 1;
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam logic [K_W-1:0]             K_LAST  = K_W'(N - 1);
  localparam logic [FIFO_DEPTH_LOG2:0]   LVL_ONE = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};

  logic [31:0]                r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rptr;
  logic [FIFO_DEPTH_LOG2:0]   r_level;
  logic [K_W-1:0]             r_k;
  logic [31:0]                r_partial;
  logic                       r_tlast_det;
  logic [N-1:0]               r_last_wstrb;
  logic [DATA_W-1:0]          r_rdata;
  logic                       r_rvalid;

  logic        w_tready;
  logic        w_accept;
  logic        w_push;
  logic        w_read;
  logic        w_pop;
  logic [2:0]  w_sel;
  logic [31:0] w_packed;
  logic [N-1:0] w_strb_next;
  logic [31:0] w_rd_word;
  logic        w_unused;

  assign w_unused = ^{iob_wdata, iob_addr};

  // Level MSB set means exactly DEPTH words stored: the FIFO is full.
  assign w_tready = ~r_tlast_det & ~r_level[FIFO_DEPTH_LOG2];
  assign w_accept = tvalid & w_tready;
  assign w_push   = w_accept & ((r_k == K_LAST) | tlast);
  assign w_read   = iob_avalid & ~(|iob_wstrb);
  assign w_sel    = iob_addr[4:2];
  assign w_pop    = w_read & (w_sel == 3'd0) & (r_level != '0);

  assign iob_ready  = 1'b1;
  assign iob_rdata  = r_rdata;
  assign iob_rvalid = r_rvalid;
  assign tready     = w_tready;

  // Lanes above k are still zero in the partial word, so a short word is already zero-padded.
  always_comb begin
    w_packed    = r_partial;
    w_strb_next = '0;
    for (int i = 0; i < N; i++) begin
      if (r_k == K_W'(i)) w_packed[i*TDATA_W +: TDATA_W] = tdata;
      w_strb_next[i] = (K_W'(i) <= r_k);
    end
  end

  always_comb begin
    w_rd_word = '0;
    case (w_sel)
      3'd0: w_rd_word = (r_level != '0) ? r_mem[r_rptr] : 32'd0;
      3'd1: w_rd_word = {31'd0, (r_level == '0)};
      3'd2: w_rd_word = 32'(r_last_wstrb);
      3'd3: w_rd_word = {31'd0, r_tlast_det};
`ifdef IOB_AXISTREAM_IN_LEVEL_EN
      3'd4: w_rd_word = 32'(r_level);
`endif
      default: w_rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_packed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_k          <= '0;
      r_partial    <= '0;
      r_tlast_det  <= 1'b0;
      r_last_wstrb <= '0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
    end else begin
      r_rvalid <= w_read;
      r_rdata  <= w_read ? DATA_W'(w_rd_word) : '0;

      if (w_accept) begin
        r_k       <= w_push ? '0 : r_k + 1'b1;
        r_partial <= w_push ? '0 : w_packed;
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase

      // A pending tlast blocks tready, so the draining pop can never coincide with a push.
      if (w_accept & tlast) begin
        r_tlast_det  <= 1'b1;
        r_last_wstrb <= w_strb_next;
      end else if (w_pop & r_tlast_det & (r_level == LVL_ONE)) begin
        r_tlast_det  <= 1'b0;
        r_last_wstrb <= '0;
      end
    end
  end

endmodule

// File: tb/tb_iob_axistream_in.sv
// Bench for iob_axistream_in (TDATA_W=8, 16-word FIFO): directed scenarios plus a random
// sequence, each checked against a frame/queue model of the receiver.
module tb_iob_axistream_in;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        iob_avalid;
  logic [4:0]  iob_addr;
  logic [31:0] iob_wdata;
  logic [3:0]  iob_wstrb;
  logic [31:0] iob_rdata;
  logic        iob_rvalid;
  logic        iob_ready;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  int checks   = 0;
  int failures = 0;

  // Model state: completed words, beats of the current word, end-of-frame flags.
  logic [31:0] exp_q[$];
  logic [7:0]  m_beats[$];
  logic        m_tlast;
  logic [3:0]  m_wstrb;

  always #5 clk = ~clk;

  iob_axistream_in dut (
    .clk        (clk),
    .rst        (rst),
    .iob_avalid (iob_avalid),
    .iob_addr   (iob_addr),
    .iob_wdata  (iob_wdata),
    .iob_wstrb  (iob_wstrb),
    .iob_rdata  (iob_rdata),
    .iob_rvalid (iob_rvalid),
    .iob_ready  (iob_ready),
    .tdata      (tdata),
    .tvalid     (tvalid),
    .tready     (tready),
    .tlast      (tlast)
  );

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a[4:2])
      3'd0: return (exp_q.size() != 0) ? exp_q[0] : 32'd0;
      3'd1: return {31'd0, exp_q.size() == 0};
      3'd2: return {28'd0, m_wstrb};
      3'd3: return {31'd0, m_tlast};
`ifdef IOB_AXISTREAM_IN_LEVEL_EN
      3'd4: return 32'(exp_q.size());
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock cycle: present a beat and/or a CPU access, check tready before the edge
  // and the read response after it, then advance the model.
  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic rd, input logic wr, input logic [4:0] a, output logic acc);
    logic        exp_tready;
    logic [31:0] exp_rd;
    logic        do_pop;
    logic [31:0] word;
    @(negedge clk);
    tvalid     = v;
    tdata      = d;
    tlast      = l;
    iob_avalid = rd | wr;
    iob_addr   = a;
    iob_wstrb  = wr ? 4'hF : 4'h0;
    iob_wdata  = $urandom;
    exp_tready = !m_tlast && (exp_q.size() < DEPTH);
    #1;
    checks++;
    if (tready !== exp_tready) begin
      failures++;
      $display("FAIL tready: got %b expected %b", tready, exp_tready);
    end
    acc    = v && exp_tready;
    exp_rd = model_read(a);
    do_pop = rd && (a[4:2] == 3'd0) && (exp_q.size() != 0);
    @(posedge clk);
    #1;
    checks++;
    if (iob_rvalid !== rd) begin
      failures++;
      $display("FAIL rvalid: got %b expected %b", iob_rvalid, rd);
    end
    if (rd) begin
      checks++;
      if (iob_rdata !== exp_rd) begin
        failures++;
        $display("FAIL rdata@%0h: got %08h expected %08h", a, iob_rdata, exp_rd);
      end
    end
    if (do_pop) begin
      void'(exp_q.pop_front());
      if (m_tlast && exp_q.size() == 0) begin
        m_tlast = 1'b0;
        m_wstrb = 4'h0;
      end
    end
    if (acc) begin
      m_beats.push_back(d);
      if (m_beats.size() == 4 || l) begin
        word = 32'd0;
        foreach (m_beats[i]) word |= 32'(m_beats[i]) << (8 * i);
        exp_q.push_back(word);
        if (l) begin
          m_tlast = 1'b1;
          m_wstrb = 4'((1 << m_beats.size()) - 1);
        end
        m_beats.delete();
      end
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    logic acc;
    step(1'b1, d, l, 1'b0, 1'b0, 5'h00, acc);
  endtask

  task automatic rd_reg(input logic [4:0] a);
    logic acc;
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, a, acc);
  endtask

  task automatic do_reset(input logic rd);
    @(negedge clk);
    rst        = 1'b1;
    tvalid     = 1'b0;
    tlast      = 1'b0;
    iob_avalid = rd;
    iob_addr   = 5'h00;
    iob_wstrb  = 4'h0;
    @(posedge clk);
    #1;
    checks++;
    if (iob_rvalid !== 1'b0 || iob_rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rvalid=%b rdata=%08h expected 0/0", iob_rvalid, iob_rdata);
    end
    @(negedge clk);
    rst        = 1'b0;
    iob_avalid = 1'b0;
    exp_q.delete();
    m_beats.delete();
    m_tlast = 1'b0;
    m_wstrb = 4'h0;
    #1;
    checks++;
    if (tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_tready: got %b expected 1", tready);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) rd_reg(5'(i * 4));
  endtask

  task automatic test_pack();
    beat(8'h11, 1'b0); beat(8'h22, 1'b0); beat(8'h33, 1'b0); beat(8'h44, 1'b0);
    rd_reg(5'h04);
    rd_reg(5'h00);
    rd_reg(5'h04);
  endtask

  task automatic test_tlast();
    beat(8'hAA, 1'b0);
    beat(8'hBB, 1'b1);
    rd_reg(5'h0C);
    rd_reg(5'h08);
    rd_reg(5'h00);
    rd_reg(5'h0C);
    rd_reg(5'h08);
    beat(8'h5A, 1'b1);
    rd_reg(5'h00);
  endtask

  task automatic test_empty_read();
    rd_reg(5'h00);
    rd_reg(5'h10);
    rd_reg(5'h04);
    rd_reg(5'h18);
    rd_reg(5'h1C);
  endtask

  task automatic test_full();
    logic acc;
    int   waits;
    do_reset(1'b0);
    for (int i = 0; i < DEPTH * 4; i++) beat(8'($urandom), 1'b0);
    rd_reg(5'h10);
    step(1'b1, 8'hE5, 1'b0, 1'b0, 1'b0, 5'h00, acc);
    step(1'b1, 8'hE5, 1'b0, 1'b1, 1'b0, 5'h00, acc);
    waits = 0;
    acc   = 1'b0;
    while (!acc && waits < 20) begin
      step(1'b1, 8'hE5, 1'b0, 1'b0, 1'b0, 5'h00, acc);
      waits++;
    end
    checks++;
    if (!acc || waits != 1) begin
      failures++;
      $display("FAIL full_resume: got accepted=%b after %0d cycles expected 1 after 1", acc, waits);
    end
    for (int i = 0; i < DEPTH + 1; i++) rd_reg(5'h00);
    rd_reg(5'h04);
  endtask

  task automatic test_simul_push_pop();
    logic acc;
    do_reset(1'b0);
    for (int i = 0; i < 11; i++) beat(8'($urandom), 1'b0);
    rd_reg(5'h10);
    step(1'b1, 8'h7E, 1'b0, 1'b1, 1'b0, 5'h00, acc);
    rd_reg(5'h10);
    rd_reg(5'h00);
    rd_reg(5'h00);
    rd_reg(5'h04);
  endtask

  task automatic test_write_ignored();
    logic acc;
    beat(8'hC1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'h00, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'h0C, acc);
    rd_reg(5'h0C);
    rd_reg(5'h08);
    rd_reg(5'h00);
  endtask

  task automatic test_rst_mid();
    beat(8'hF1, 1'b0);
    beat(8'hF2, 1'b0);
    do_reset(1'b1);
    rd_reg(5'h04);
    rd_reg(5'h0C);
    beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b0);
    rd_reg(5'h00);
  endtask

  task automatic test_random();
    logic       acc;
    logic       v, l, rd, wr;
    logic [4:0] a;
    for (int i = 0; i < 400; i++) begin
      v  = 1'($urandom_range(0, 1));
      l  = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 2) == 0);
      wr = !rd && ($urandom_range(0, 7) == 0);
      a  = ($urandom_range(0, 1) == 0) ? 5'h00 : 5'($urandom_range(0, 7) * 4);
      step(v, 8'($urandom), l, rd, wr, a, acc);
    end
  endtask

  initial begin
    rst        = 1'b1;
    iob_avalid = 1'b0;
    iob_addr   = '0;
    iob_wdata  = '0;
    iob_wstrb  = '0;
    tdata      = '0;
    tvalid     = 1'b0;
    tlast      = 1'b0;
    m_tlast    = 1'b0;
    m_wstrb    = 4'h0;
    test_reset();
    test_pack();
    test_tlast();
    test_empty_read();
    test_full();
    test_simul_push_pop();
    test_write_ignored();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
